// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU use a shift-add loop and DIV/DIVU use a restoring loop, one step
// per cycle for WIDTH cycles. Both run on operand magnitudes, and one final
// cycle applies the sign correction. MTHI/MTLO write HI/LO directly while idle.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset; aborts any op in flight
//   start  request, sampled only while busy=0
//   op     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   a, b   rs / rt operands
//   busy   high while an arithmetic op is in flight
//   done   one-cycle pulse when hi/lo first show a new arithmetic result
//   hi, lo HI / LO registers
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             is_sgn_q, is_sgn_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [AW-1:0]    acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_hold_q, a_hold_d;
  logic             busy_d, done_d;
  logic [WIDTH-1:0] hi_d, lo_d;

  // Two's-complement magnitude in WIDTH+1 bits so the most negative value is exact.
  function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] x, input logic neg);
    mag = neg ? ((WIDTH + 1)'(0) - {x[WIDTH-1], x}) : {1'b0, x};
  endfunction

  logic             sgn_op;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   a_mag, b_mag;

  assign sgn_op = ~op[0];
  assign a_neg  = sgn_op & a[WIDTH-1];
  assign b_neg  = sgn_op & b[WIDTH-1];
  assign a_mag  = mag(a, a_neg);
  assign b_mag  = mag(b, b_neg);

  // One shift-add step: conditionally add the multiplicand to the upper half, then shift right.
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_step;
  assign mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? opnd_q : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring-division step: shift left, trial-subtract, keep on non-negative.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [AW-1:0]    div_step;
  assign rem_sh   = acc_q[AW-1:WIDTH-1];
  assign dvd_sh   = {acc_q[WIDTH-2:0], 1'b0};
  assign div_diff = {1'b0, rem_sh} - {1'b0, opnd_q};
  assign div_ok   = ~div_diff[WIDTH+1];
  assign div_step = div_ok ? {div_diff[WIDTH-1:0], dvd_sh[WIDTH-1:1], 1'b1}
                           : {rem_sh[WIDTH-1:0], dvd_sh};

  // Sign correction applied in the FIX cycle.
  logic             neg_res;
  logic [AW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign neg_res  = is_sgn_q & (sa_q ^ sb_q);
  assign prod_fix = neg_res ? -acc_q : acc_q;
  assign quo_fix  = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = (is_sgn_q & sa_q) ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];

  // Carry-out bit of the trial subtraction below the sign is never needed.
  logic unused_bits;
  assign unused_bits = &{1'b0, div_diff[WIDTH]};

  // Next-state and next-register logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    is_sgn_d = is_sgn_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_hold_d = a_hold_q;
    busy_d   = busy;
    done_d   = 1'b0;
    hi_d     = hi;
    lo_d     = lo;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (!op[2]) begin
            state_d  = CALC;
            busy_d   = 1'b1;
            cnt_d    = CW'(WIDTH);
            is_div_d = op[1];
            is_sgn_d = sgn_op;
            sa_d     = a_neg;
            sb_d     = b_neg;
            a_hold_d = a;
            if (op[1]) begin
              acc_d  = {{WIDTH{1'b0}}, a_mag[WIDTH-1:0]};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, b_mag[WIDTH-1:0]};
              opnd_d = a_mag;
            end
          end else if (!op[1]) begin
            if (op[0]) lo_d = a;
            else       hi_d = a;
          end
        end
      end

      CALC: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end

      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[AW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (opnd_q == '0) begin
          // Divide by zero: all-ones quotient, dividend passed through untouched.
          hi_d = a_hold_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      is_sgn_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_hold_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      is_sgn_q <= is_sgn_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_hold_q <= a_hold_d;
      busy     <= busy_d;
      done     <= done_d;
      hi       <= hi_d;
      lo       <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases followed by randomized ops,
// compared against an arithmetic reference model of HI/LO.
module tb_mdu_iter;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [31:0]  m_hi = '0;
  logic [31:0]  m_lo = '0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: HI/LO as defined by the MIPS multiply/divide semantics.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = 64'(sx * sy); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = {32'd0, x} * {32'd0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin
        if (y == 0) begin m_lo = '1; m_hi = x; end
        else begin q = sx / sy; r = sx % sy; m_lo = 32'(q); m_hi = 32'(r); end
      end
      3'd3: begin
        if (y == 0) begin m_lo = '1; m_hi = x; end
        else begin m_lo = x / y; m_hi = x % y; end
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'h0000_0000;
      1: pick = 32'h0000_0001;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'h8000_0000;
      4: pick = 32'h7FFF_FFFF;
      default: pick = $urandom();
    endcase
  endfunction

  // Issue an arithmetic op, optionally pulse a second request at cycle inj_cyc, check result.
  task automatic run_arith(input string tag, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input int inj_cyc,
                           input logic [2:0] inj_op, input logic [31:0] inj_a);
    int cyc;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    model(o, x, y);
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    while (!done && cyc < 100) begin
      if (cyc == inj_cyc) begin start = 1'b1; op = inj_op; a = inj_a; end
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == 32) check({tag, "_busy_last"}, 64'(busy), 64'd1);
    end
    check({tag, "_latency"}, 64'(cyc), 64'd33);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(lo), 64'(m_lo));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  // Issue a non-arithmetic op (MTHI/MTLO/no-op) while idle.
  task automatic run_mt(input string tag, input logic [2:0] o, input logic [31:0] x);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = $urandom();
    @(negedge clk);
    start = 1'b0;
    model(o, x, 32'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  ro;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    rst = 1'b0;

    // Directed cases.
    run_arith("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 3'd0, 32'd0);
    check("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max_lo_const", 64'(lo), 64'h0000_0001);
    run_arith("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, -1, 3'd0, 32'd0);
    check("mult_neg_lo_const", 64'(lo), 64'hFFFF_FFF1);
    run_arith("divu_7_2", 3'd3, 32'd7, 32'd2, -1, 3'd0, 32'd0);
    check("divu_7_2_hi_const", 64'(hi), 64'd1);
    run_arith("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, -1, 3'd0, 32'd0);
    check("div_neg7_2_lo_const", 64'(lo), 64'hFFFF_FFFD);
    run_arith("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 3'd0, 32'd0);
    check("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
    run_arith("divu_by0", 3'd3, 32'd5, 32'd0, -1, 3'd0, 32'd0);
    check("divu_by0_hi_const", 64'(hi), 64'd5);
    run_arith("div_neg_by0", 3'd2, 32'hFFFF_FF00, 32'd0, -1, 3'd0, 32'd0);
    run_arith("mult_minmin", 3'd0, 32'h8000_0000, 32'h8000_0000, -1, 3'd0, 32'd0);
    run_arith("div_rem_sign", 3'd2, 32'd7, 32'hFFFF_FFFE, -1, 3'd0, 32'd0);

    // MTHI pulsed while busy must be ignored; then accepted while idle.
    run_arith("mult_inj", 3'd0, 32'd3, 32'd5, 5, 3'd4, 32'h0000_1234);
    run_mt("mthi", 3'd4, 32'h0000_1234);
    check("mthi_hi_const", 64'(hi), 64'h0000_1234);
    run_mt("mtlo", 3'd5, 32'hCAFE_0001);
    run_mt("nop", 3'd6, 32'hDEAD_BEEF);
    run_arith("multu_zero", 3'd1, 32'd0, 32'h1234_5678, -1, 3'd0, 32'd0);

    // Reset mid-division aborts the op and clears HI/LO.
    run_arith("pre_abort", 3'd1, 32'h1111_1111, 32'h10, -1, 3'd0, 32'd0);
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'hFFFF_FF9C; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    run_arith("after_abort", 3'd1, 32'd2, 32'd3, -1, 3'd0, 32'd0);
    check("after_abort_lo_const", 64'(lo), 64'd6);

    // Randomized ops against the model.
    repeat (24) begin
      ro = 3'($urandom_range(0, 7));
      if (ro < 3'd4) run_arith("rand_arith", ro, pick(), pick(), -1, 3'd0, 32'd0);
      else           run_mt("rand_mt", ro, $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
